// File: rtl/noc_packet_injector_if.sv
// rtl/noc_packet_injector_if.sv - NoC injection link: packet, source port and valid/ready handshake
interface noc_packet_injector_if #(
    parameter int packet_width = 38
) ();
    logic                    out_valid;
    logic                    out_ready;
    logic [packet_width-1:0] packet_out;
    logic [1:0]              out_port_id;

    modport master (
        output out_valid,
        output packet_out,
        output out_port_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  packet_out,
        input  out_port_id,
        output out_ready
    );
endinterface

// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - four drop-on-full input FIFOs round-robin arbitrated onto one NoC link
module noc_packet_injector #(
    parameter int datawidth            = 16,
    parameter int address_vector_width = 4,
    parameter int packet_width         = 2 + 2*datawidth + address_vector_width,
    parameter int fifo_depth           = 4,
    parameter int ptr_width            = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [packet_width-1:0] packet_in_0,
    input  logic [packet_width-1:0] packet_in_1,
    input  logic [packet_width-1:0] packet_in_2,
    input  logic [packet_width-1:0] packet_in_3,
    input  logic                    scenario_update,
    noc_packet_injector_if.master   link,
    output logic [3:0]              fifo_full,
    output logic [3:0]              overflow
);
    localparam int cnt_width = ptr_width + 1;

    logic [packet_width-1:0] pin [4];
    logic [packet_width-1:0] mem [4][fifo_depth];
    logic [ptr_width-1:0]    wr_ptr [4];
    logic [ptr_width-1:0]    rd_ptr [4];
    logic [cnt_width-1:0]    count [4];

    logic [3:0]              push, pop, drop;
    logic [1:0]              rr_ptr, grant, scan_idx;
    logic                    any_ne, load;

    logic                    out_valid_q;
    logic [packet_width-1:0] packet_q;
    logic [1:0]              port_q;

    assign pin[0] = packet_in_0;
    assign pin[1] = packet_in_1;
    assign pin[2] = packet_in_2;
    assign pin[3] = packet_in_3;

    assign link.out_valid   = out_valid_q;
    assign link.packet_out  = packet_q;
    assign link.out_port_id = port_q;

    assign load = !out_valid_q || link.out_ready;

    // First non-empty port at or after rr_ptr, wrapping mod 4.
    always_comb begin
        grant    = rr_ptr;
        any_ne   = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!any_ne && count[scan_idx] != '0) begin
                grant  = scan_idx;
                any_ne = 1'b1;
            end
        end
    end

    // A full FIFO still accepts when its own head is popped in the same cycle.
    always_comb begin
        push      = '0;
        pop       = '0;
        drop      = '0;
        fifo_full = '0;
        for (int k = 0; k < 4; k++) begin
            fifo_full[k] = (count[k] == cnt_width'(fifo_depth));
            pop[k]       = load && any_ne && (grant == 2'(k));
            push[k]      = !reset && pin[k][packet_width-1] && !(fifo_full[k] && !pop[k]);
            drop[k]      = !reset && pin[k][packet_width-1] && fifo_full[k] && !pop[k];
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= pin[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            out_valid_q <= 1'b0;
            packet_q    <= '0;
            port_q      <= '0;
            overflow    <= '0;
            rr_ptr      <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + ptr_width'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + ptr_width'(1);
                end
                count[k] <= count[k] + cnt_width'(push[k]) - cnt_width'(pop[k]);
            end
            // A drop in the same cycle as the clear pulse leaves its bit set.
            overflow <= (scenario_update ? 4'b0000 : overflow) | drop;
            if (load) begin
                if (any_ne) begin
                    out_valid_q <= 1'b1;
                    packet_q    <= mem[grant][rd_ptr[grant]];
                    port_q      <= grant;
                    rr_ptr      <= grant + 2'd1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - directed self-checking bench for noc_packet_injector
module tb_noc_packet_injector;
    localparam int pw = 38;

    logic          CLK = 1'b0;
    logic          reset;
    logic [pw-1:0] packet_in_0, packet_in_1, packet_in_2, packet_in_3;
    logic          scenario_update;
    logic [3:0]    fifo_full, overflow;

    int checks = 0;
    int errors = 0;

    noc_packet_injector_if #(.packet_width(pw)) link ();

    noc_packet_injector dut (
        .CLK             (CLK),
        .reset           (reset),
        .packet_in_0     (packet_in_0),
        .packet_in_1     (packet_in_1),
        .packet_in_2     (packet_in_2),
        .packet_in_3     (packet_in_3),
        .scenario_update (scenario_update),
        .link            (link),
        .fifo_full       (fifo_full),
        .overflow        (overflow)
    );

    always #5 CLK = ~CLK;

    function automatic logic [pw-1:0] pk(input logic [1:0] dest, input logic [31:0] d);
        logic [3:0] one = 4'b0001;
        return {2'b10, d, one << dest};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [pw-1:0] p, input logic [1:0] port);
        chk({tag, "_valid"}, 64'(link.out_valid), 64'd1);
        chk({tag, "_pkt"}, 64'(link.packet_out), 64'(p));
        chk({tag, "_port"}, 64'(link.out_port_id), 64'(port));
    endtask

    task automatic clear_inputs();
        packet_in_0 = '0;
        packet_in_1 = '0;
        packet_in_2 = '0;
        packet_in_3 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [pw-1:0] p2, x_pkt, y_pkt, a_pkt, c_pkt;

    initial begin
        clear_inputs();
        scenario_update = 1'b0;
        link.out_ready  = 1'b1;
        do_reset();

        chk("rst_valid", 64'(link.out_valid), 64'd0);
        chk("rst_pkt", 64'(link.packet_out), 64'd0);
        chk("rst_port", 64'(link.out_port_id), 64'd0);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Single packet latency: presented cycle n, visible cycle n+2.
        p2 = {2'b10, 32'h0000_0019, 4'b1000};
        packet_in_2 = p2;
        tick();
        clear_inputs();
        chk("lat_n1_valid", 64'(link.out_valid), 64'd0);
        tick();
        chk_out("lat_n2", p2, 2'd2);
        tick();
        chk("lat_n3_valid", 64'(link.out_valid), 64'd0);
        chk("lat_n3_hold", 64'(link.packet_out), 64'(p2));

        // Valid bit low: never stored.
        packet_in_0 = {2'b01, 32'hDEAD_BEEF, 4'b0001};
        tick();
        clear_inputs();
        tick();
        chk("inv_valid", 64'(link.out_valid), 64'd0);
        tick();
        chk("inv_valid2", 64'(link.out_valid), 64'd0);

        // Simultaneous burst on all ports, twice, from rr_ptr=0.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            packet_in_0 = pk(2'd1, 32'h100 + 32'(b));
            packet_in_1 = pk(2'd2, 32'h200 + 32'(b));
            packet_in_2 = pk(2'd3, 32'h300 + 32'(b));
            packet_in_3 = pk(2'd0, 32'h400 + 32'(b));
            tick();
            clear_inputs();
            tick();
            chk_out("burst_p0", pk(2'd1, 32'h100 + 32'(b)), 2'd0);
            tick();
            chk_out("burst_p1", pk(2'd2, 32'h200 + 32'(b)), 2'd1);
            tick();
            chk_out("burst_p2", pk(2'd3, 32'h300 + 32'(b)), 2'd2);
            tick();
            chk_out("burst_p3", pk(2'd0, 32'h400 + 32'(b)), 2'd3);
            tick();
            chk("burst_end_valid", 64'(link.out_valid), 64'd0);
        end

        // Overflow: stall output with a port-1 packet, then stream six on port 0.
        do_reset();
        link.out_ready = 1'b0;
        x_pkt = pk(2'd0, 32'hAAAA_0001);
        packet_in_1 = x_pkt;
        tick();
        clear_inputs();
        tick();
        chk_out("ovf_stall", x_pkt, 2'd1);
        for (int i = 0; i < 6; i++) begin
            packet_in_0 = pk(2'd2, 32'(i));
            tick();
            if (i == 2) chk("ovf_full_3", 64'(fifo_full), 64'h0);
            if (i == 3) chk("ovf_full_4", 64'(fifo_full), 64'h1);
            if (i == 3) chk("ovf_none_4", 64'(overflow), 64'h0);
            if (i == 4) chk("ovf_set_5", 64'(overflow), 64'h1);
        end
        clear_inputs();
        chk("ovf_set_6", 64'(overflow), 64'h1);
        chk_out("ovf_still_held", x_pkt, 2'd1);
        link.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("ovf_drain", pk(2'd2, 32'(i)), 2'd0);
        end
        tick();
        chk("ovf_drain_end", 64'(link.out_valid), 64'd0);

        // Clear pulse without a drop.
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        chk("su_clear", 64'(overflow), 64'h0);

        // Clear pulse coinciding with a drop.
        link.out_ready = 1'b0;
        y_pkt = pk(2'd3, 32'hBBBB_0002);
        packet_in_1 = y_pkt;
        tick();
        clear_inputs();
        tick();
        chk_out("su_stall", y_pkt, 2'd1);
        for (int i = 0; i < 4; i++) begin
            packet_in_0 = pk(2'd1, 32'h50 + 32'(i));
            tick();
        end
        packet_in_0 = pk(2'd1, 32'h54);
        tick();
        chk("su_drop_pre", 64'(overflow), 64'h1);
        packet_in_0 = pk(2'd1, 32'h55);
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        clear_inputs();
        chk("su_drop_wins", 64'(overflow), 64'h1);

        // Release one packet; rr_ptr=2 wraps to port 0; leaves 3 queued, then stall.
        link.out_ready = 1'b1;
        tick();
        link.out_ready = 1'b0;
        chk_out("pre_rst_pkt", pk(2'd1, 32'h50), 2'd0);
        tick();
        chk_out("pre_rst_hold", pk(2'd1, 32'h50), 2'd0);
        chk("pre_rst_full", 64'(fifo_full), 64'h0);

        // Reset mid-stall, with packets presented during reset.
        reset = 1'b1;
        packet_in_0 = pk(2'd0, 32'h99);
        packet_in_2 = pk(2'd0, 32'h98);
        tick();
        reset = 1'b0;
        clear_inputs();
        chk("mid_rst_valid", 64'(link.out_valid), 64'd0);
        chk("mid_rst_pkt", 64'(link.packet_out), 64'd0);
        chk("mid_rst_port", 64'(link.out_port_id), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'h0);
        chk("mid_rst_full", 64'(fifo_full), 64'h0);
        link.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_empty", 64'(link.out_valid), 64'd0);
        end

        // Stall for 3 cycles while port 1 streams, then round-robin resumes.
        link.out_ready = 1'b0;
        a_pkt = pk(2'd2, 32'hCCCC_0000);
        c_pkt = pk(2'd1, 32'hCCCC_0003);
        packet_in_0 = a_pkt;
        tick();
        clear_inputs();
        tick();
        chk_out("st_start", a_pkt, 2'd0);
        for (int i = 0; i < 3; i++) begin
            packet_in_1 = pk(2'd0, 32'h10 + 32'(i));
            packet_in_3 = (i == 0) ? c_pkt : '0;
            tick();
            chk_out("st_hold", a_pkt, 2'd0);
        end
        clear_inputs();
        link.out_ready = 1'b1;
        tick();
        chk_out("st_rr0", pk(2'd0, 32'h10), 2'd1);
        tick();
        chk_out("st_rr1", c_pkt, 2'd3);
        tick();
        chk_out("st_rr2", pk(2'd0, 32'h11), 2'd1);
        tick();
        chk_out("st_rr3", pk(2'd0, 32'h12), 2'd1);
        tick();
        chk("st_end_valid", 64'(link.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Downstream consumer of the four ring-connected local controllers (DUT0..DUT3 ring).
- Captures each controller's free-running packet_out stream into a small per-port FIFO.
- Round-robin arbitrates the four streams onto one NoC injection link with a valid/ready handshake.
- Controllers cannot stall, so packets arriving at a full FIFO are dropped. Each drop is flagged with a sticky per-port overflow bit.

Parameters:
- datawidth, 16, sample half-width; the data field is 2*datawidth.
- address_vector_width, 4, one-hot destination vector width.
- packet_width, 2 + 2*datawidth + address_vector_width (38), full packet width.
- fifo_depth, 4, entries per input FIFO; must be a power of two.
- ptr_width, 2, log2(fifo_depth).

Ports:
- CLK  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- packet_in_0  input  packet_width  packet from local controller 0; likewise packet_in_1..packet_in_3 for controllers 1..3.
- scenario_update  input  1  one-cycle pulse; clears overflow flags.
- out_ready  input  1  NoC link accepts packet_out this cycle.
- out_valid  output  1  packet_out holds a valid packet.
- packet_out  output  packet_width  arbitrated packet, unmodified.
- out_port_id  output  2  source port of packet_out.
- fifo_full  output  4  per-port FIFO full, combinational from counters.
- overflow  output  4  sticky per-port drop flag.

Behaviour:
- Packet format, decided:
  - [packet_width-1]: valid.
  - [packet_width-2]: tail/boundary.
  - [packet_width-3:address_vector_width]: data.
  - [address_vector_width-1:0]: dest one-hot.
- Enqueue: packet_in_k is written into FIFO k on a posedge when its valid bit is 1 and the FIFO is not full after this cycle's dequeue.
- Invalid packets (valid bit 0) are never stored.
- Full FIFO with a dequeue from that same port in the same cycle: the incoming packet is accepted; occupancy is unchanged.
- Full FIFO without a same-cycle dequeue: the packet is dropped, overflow[k] is set to 1, and FIFO contents are untouched.
- FIFO pointers wrap modulo fifo_depth. Each FIFO keeps a ptr_width+1 bit occupancy counter, 0..fifo_depth. fifo_full[k] = (count == fifo_depth).
- Output register loads when (!out_valid || out_ready):
  - If any FIFO is non-empty, the grant goes to the first non-empty port scanning from rr_ptr upward, mod 4.
  - The granted FIFO head is popped into packet_out, out_port_id gets the port, out_valid = 1, and rr_ptr becomes grant+1 mod 4.
  - If all FIFOs are empty, out_valid goes to 0. packet_out and out_port_id hold their last value.
- Stall: while out_valid && !out_ready, packet_out, out_port_id and out_valid are held unchanged, no pop occurs, and rr_ptr holds.
- Throughput: one packet per cycle when out_ready is held at 1.
- Latency: a packet presented in cycle n, with its FIFO empty and the link idle, appears on packet_out with out_valid=1 in cycle n+2.
- Ordering: per-port FIFO order is preserved; there is no cross-port ordering guarantee.
- overflow clear: scenario_update clears all overflow bits. If a drop occurs in the same cycle as scenario_update, the drop wins and that bit reads 1. FIFOs are not flushed by scenario_update.
- Reset (any cycle, including mid-stall) sets:
  - All FIFO pointers and counts to 0.
  - out_valid=0, packet_out=0, out_port_id=0.
  - overflow=0, rr_ptr=0.
  - Packets presented during reset are discarded.

Test Plan:
- After reset, packet_in_2 = {2'b10, 32'h0000_0019, 4'b1000} for one cycle with out_ready=1 -> two cycles later: out_valid=1, packet_out = that value, out_port_id=2; out_valid=0 the following cycle.
- All four ports present valid packets in the same cycle, out_ready=1 -> output order is ports 0,1,2,3 in consecutive cycles. A repeat burst starts from rr_ptr=0 again.
- out_ready=0, port 0 streams 6 consecutive valid packets with D = 32'h0, 32'h1, ... -> fifo_full[0]=1 after the 4th, packets 5 and 6 are dropped, overflow[0]=1. With out_ready=1, exactly D=0..3 emerge in order.
- overflow[0]=1, then scenario_update pulse with no drop -> overflow[0]=0 next cycle. A pulse coinciding with a new drop -> overflow[0] stays 1.
- out_valid=1 with out_ready=0 held for 3 cycles while port 1 streams -> packet_out stable for all 3 cycles, no pop. When out_ready rises, the held packet transfers and the next grant follows round-robin from rr_ptr.
- reset asserted while FIFOs hold 3 packets and out_valid=1 -> next cycle: out_valid=0, all counts 0, overflow=0, and no stale packets emerge after reset is released.
